queue_bank: RTL
===============

Name: queue_bank

Overview:
Bank of NUMBER_OF_QUEUES independent FIFO queues on the producer side of the fixed-priority selector. Producers push tagged entries into a chosen queue. The bank exports a per-queue empty vector to the selector and consumes the selector's queue id to dequeue one entry per cycle. Output is registered with 1-cycle latency.

Parameters:
NUMBER_OF_QUEUES, 4, number of queues; must be >= 2.
QUEUE_DEPTH, 8, entries per queue; must be a power of 2 and >= 2.
DATA_WIDTH, 32, payload width in bits.

Ports:
clock  input  1  single clock for all state.
reset  input  1  synchronous, active-high.
in_valid  input  1  push request.
in_queue  input  $clog2(NUMBER_OF_QUEUES)  target queue of the push.
in_data  input  DATA_WIDTH  push payload.
in_ready  output  1  push accepted this cycle when in_valid && in_ready.
empty  output  NUMBER_OF_QUEUES  bit q=1 when queue q holds 0 entries; feeds the selector.
full  output  NUMBER_OF_QUEUES  bit q=1 when queue q holds QUEUE_DEPTH entries.
pop  input  1  dequeue request for the queue given by selection.
selection  input  $clog2(NUMBER_OF_QUEUES)  queue id from the selector.
out_valid  output  1  out_data/out_queue valid this cycle.
out_data  output  DATA_WIDTH  dequeued payload.
out_queue  output  $clog2(NUMBER_OF_QUEUES)  id of the queue the payload came from.
pop_miss_count  output  16  saturating count of pops issued to an empty queue.

Behaviour:
- Clock and reset: single clock, reset synchronous active-high; everything updates on posedge clock.
- Per-queue state: storage[QUEUE_DEPTH] x DATA_WIDTH, rd_ptr and wr_ptr of width $clog2(QUEUE_DEPTH) that wrap modulo QUEUE_DEPTH, and count of width $clog2(QUEUE_DEPTH)+1.
- empty[q] = (count[q]==0) and full[q] = (count[q]==QUEUE_DEPTH). Both derive combinationally from registered count only, with no path from pop or in_* inputs.
- in_ready = !full[in_queue], combinational from in_queue and registered state. It does not depend on a same-cycle pop (no pop-to-ready path).
- Push accepted (in_valid && in_ready): storage[in_queue][wr_ptr] <= in_data; wr_ptr advances; count +1.
- Pop accepted (pop && !empty[selection]): out_data <= storage[selection][rd_ptr] and out_queue <= selection at the next edge. Also out_valid <= 1, rd_ptr advances, count -1.
- Pop miss (pop && empty[selection]): no state change in queues; out_valid <= 0; pop_miss_count +1, saturating at 16'hFFFF.
- No pop: out_valid <= 0. out_data and out_queue hold their last values.
- Latency: the accepted pop at edge N presents data during cycle N+1. One pop and one push maximum per cycle.
- Simultaneous push and pop, same queue, nonempty and not full: both take effect and count is unchanged. Pop returns the oldest entry, not the one being pushed.
- Same queue, empty: the push is accepted and the pop is a miss, because empty reflects the pre-edge state. The entry becomes visible next cycle.
- Same queue, full: in_ready=0 and the push is rejected. The pop is accepted and count becomes QUEUE_DEPTH-1.
- Different queues: the push and pop are independent.
- Wrap-around: pointers roll from QUEUE_DEPTH-1 to 0. Strict FIFO order is preserved within each queue across any number of wraps.
- Reset values:
  - all counts and pointers 0, so empty = all ones and full = 0;
  - in_ready = 1;
  - out_valid = 0, out_data = 0, out_queue = 0;
  - pop_miss_count = 0.
  - Storage contents are not reset.
- Reset mid-operation: all queued entries are discarded. An out_valid pending from the previous cycle is forced to 0 in the reset cycle, and pushes/pops presented during reset are ignored.
- The selector's convention places queue 0 in its chain first; the bank imposes no ordering, it simply obeys selection.

Test Plan:
- Reset, then idle -> empty=4'b1111, full=0, in_ready=1, out_valid=0, pop_miss_count=0.
- Push 0xA0..0xA7 into queue 2 -> full=4'b0100 and in_ready=0 for in_queue=2. A 9th push is not accepted. 8 pops with selection=2 return 0xA0..0xA7 in order, each 1 cycle after its pop, with out_queue=2. Afterwards empty[2]=1.
- Queue 1 holding 3 entries, 10 rounds of one push + one pop same cycle -> count stays 3 and outputs are strictly FIFO across the pointer wrap.
- Queue 3 full, push(0x55) and pop same cycle -> push rejected, oldest entry returned, count=7, full[3]=0 next cycle.
- Queue 0 empty, push(0x11) and pop(sel=0) same cycle -> out_valid=0 next cycle and pop_miss_count=1. The next pop returns 0x11.
- Queues 0 and 2 partly filled, reset asserted for 1 cycle while a pop is in flight -> out_valid=0 and empty=4'b1111 after reset. A subsequent pop misses.

Source files
------------

// File: rtl/queue_bank.sv
// queue_bank: bank of NUMBER_OF_QUEUES independent FIFO queues feeding a
// fixed-priority selector. Producers push tagged entries into a chosen queue;
// the selector reads the per-queue empty vector and returns a queue id, and
// the bank dequeues one entry from that queue per cycle with a registered,
// one-cycle-latency output.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   in_valid/in_queue/in_data, in_ready   push interface (accept on valid&&ready)
//   empty, full           per-queue status derived from registered counts only
//   pop, selection        dequeue request for the queue chosen by the selector
//   out_valid/out_data/out_queue          registered dequeue result
//   pop_miss_count        saturating count of pops aimed at an empty queue
module queue_bank #(
   parameter int NUMBER_OF_QUEUES = 4,
   parameter int QUEUE_DEPTH      = 8,
   parameter int DATA_WIDTH       = 32
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                in_valid,
   input  logic [$clog2(NUMBER_OF_QUEUES)-1:0] in_queue,
   input  logic [DATA_WIDTH-1:0]               in_data,
   output logic                                in_ready,
   output logic [NUMBER_OF_QUEUES-1:0]         empty,
   output logic [NUMBER_OF_QUEUES-1:0]         full,
   input  logic                                pop,
   input  logic [$clog2(NUMBER_OF_QUEUES)-1:0] selection,
   output logic                                out_valid,
   output logic [DATA_WIDTH-1:0]               out_data,
   output logic [$clog2(NUMBER_OF_QUEUES)-1:0] out_queue,
   output logic [15:0]                         pop_miss_count
);

   localparam int QW = $clog2(NUMBER_OF_QUEUES);
   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int CW = PW + 1;

   logic [DATA_WIDTH-1:0] storage_r [NUMBER_OF_QUEUES][QUEUE_DEPTH];
   logic [PW-1:0]         rd_ptr_r  [NUMBER_OF_QUEUES];
   logic [PW-1:0]         wr_ptr_r  [NUMBER_OF_QUEUES];
   logic [CW-1:0]         count_r   [NUMBER_OF_QUEUES];

   logic                  out_valid_r;
   logic [DATA_WIDTH-1:0] out_data_r;
   logic [QW-1:0]         out_queue_r;
   logic [15:0]           pop_miss_count_r;

   logic [NUMBER_OF_QUEUES-1:0] empty_s;
   logic [NUMBER_OF_QUEUES-1:0] full_s;
   logic                        in_ready_s;
   logic                        sel_empty_s;
   logic [DATA_WIDTH-1:0]       pop_data_s;
   logic                        push_ok_s;
   logic                        pop_hit_s;
   logic                        pop_miss_s;

   // Status flags come from registered counts only, so no input reaches them.
   always_comb begin
      empty_s = '0;
      full_s  = '0;
      for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
         empty_s[q] = (count_r[q] == CW'(0));
         full_s[q]  = (count_r[q] == CW'(QUEUE_DEPTH));
      end
   end

   // Decode the push target and pop selection by scanning the queues, so an
   // id beyond the last queue (non power-of-two bank) is refused / treated
   // as empty instead of indexing out of range.
   always_comb begin
      in_ready_s  = 1'b0;
      sel_empty_s = 1'b1;
      pop_data_s  = '0;
      for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
         if (in_queue == QW'(q)) begin
            in_ready_s = !full_s[q];
         end else begin
            in_ready_s = in_ready_s;
         end
         if (selection == QW'(q)) begin
            sel_empty_s = empty_s[q];
            pop_data_s  = storage_r[q][rd_ptr_r[q]];
         end else begin
            sel_empty_s = sel_empty_s;
            pop_data_s  = pop_data_s;
         end
      end
   end

   // Accepted push / pop qualifiers; anything presented during reset is ignored.
   always_comb begin
      push_ok_s  = in_valid && in_ready_s && !reset;
      pop_hit_s  = pop && !sel_empty_s && !reset;
      pop_miss_s = pop && sel_empty_s && !reset;
   end

   // Payload storage is deliberately not reset; only accepted pushes write it.
   always_ff @(posedge clock) begin
      if (push_ok_s) begin
         storage_r[in_queue][wr_ptr_r[in_queue]] <= in_data;
      end
   end

   // Per-queue pointers and occupancy. A same-queue push and pop cancel in
   // the count; the pop still reads the oldest entry at rd_ptr.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
            rd_ptr_r[q] <= '0;
            wr_ptr_r[q] <= '0;
            count_r[q]  <= '0;
         end
      end else begin
         for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
            case ({push_ok_s && (in_queue == QW'(q)), pop_hit_s && (selection == QW'(q))})
               2'b10: begin
                  wr_ptr_r[q] <= wr_ptr_r[q] + PW'(1);
                  count_r[q]  <= count_r[q] + CW'(1);
               end
               2'b01: begin
                  rd_ptr_r[q] <= rd_ptr_r[q] + PW'(1);
                  count_r[q]  <= count_r[q] - CW'(1);
               end
               2'b11: begin
                  wr_ptr_r[q] <= wr_ptr_r[q] + PW'(1);
                  rd_ptr_r[q] <= rd_ptr_r[q] + PW'(1);
               end
               default: begin
                  count_r[q] <= count_r[q];
               end
            endcase
         end
      end
   end

   // Registered dequeue result; data/queue id hold when nothing is popped.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_queue_r <= '0;
      end else begin
         out_valid_r <= pop_hit_s;
         if (pop_hit_s) begin
            out_data_r  <= pop_data_s;
            out_queue_r <= selection;
         end
      end
   end

   // Saturating miss counter for pops aimed at an empty queue.
   always_ff @(posedge clock) begin
      if (reset) begin
         pop_miss_count_r <= 16'h0000;
      end else if (pop_miss_s && (pop_miss_count_r != 16'hFFFF)) begin
         pop_miss_count_r <= pop_miss_count_r + 16'h0001;
      end
   end

   assign in_ready       = in_ready_s;
   assign empty          = empty_s;
   assign full           = full_s;
   assign out_valid      = out_valid_r;
   assign out_data       = out_data_r;
   assign out_queue      = out_queue_r;
   assign pop_miss_count = pop_miss_count_r;

endmodule
